// File: rtl/us_delay_sched_if.sv
// Requester-side bundle for us_delay_sched: per-channel request, delay and
// cancel inputs together with the registered ack/busy/done/any_busy status.
interface us_delay_sched_if #(
  parameter int NCH = 4,
  parameter int DW  = 16
);
  // Handshake: a requester raises req[i] with delay[i] stable and holds both
  // until ack[i] pulses for one cycle; busy[i] rises on that same edge and
  // falls on the edge where done[i] pulses (or where cancel[i] aborts).
  logic [NCH-1:0]    req;
  logic [NCH*DW-1:0] delay;
  logic [NCH-1:0]    cancel;
  logic [NCH-1:0]    ack;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    done;
  logic              any_busy;

  modport master (
    output req, delay, cancel,
    input  ack, busy, done, any_busy
  );

  modport slave (
    input  req, delay, cancel,
    output ack, busy, done, any_busy
  );
endinterface

// File: rtl/us_delay_sched.sv
// Multi-channel microsecond delay scheduler: round-robin acceptance of one
// request per clock, then per-channel countdown on the shared 1 us tick.
module us_delay_sched #(
  parameter  int NCH = 4,
  parameter  int DW  = 16,
  localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                us_tick,
  us_delay_sched_if.slave     bus,
  output logic [NCH-1:0]      dbg_run,
  output logic [PW-1:0]       dbg_ptr
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_t;

  ch_state_t      state [NCH];
  logic [DW-1:0]  cnt   [NCH];
  logic [PW-1:0]  ptr;

  logic [NCH-1:0] run;
  logic [NCH-1:0] elig;
  logic [NCH-1:0] grant;
  logic [NCH-1:0] expire;
  logic [NCH-1:0] run_next;
  logic           found;
  logic [PW-1:0]  gidx;
  int             idx;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      run[i] = (state[i] == RUN);
    end
  end

  assign dbg_run = run;
  assign dbg_ptr = ptr;

  // First eligible channel at or after the pointer wins, wrapping to 0.
  always_comb begin
    elig  = bus.req & ~run & ~bus.cancel;
    grant = '0;
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    for (int off = 0; off < NCH; off++) begin
      idx = (int'(ptr) + off) % NCH;
      if (!found && elig[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        gidx       = PW'(idx);
      end
    end
  end

  // Expiry covers both a zero delay and the last tick of a nonzero one;
  // cancel takes priority so an aborted channel never reports done.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      expire[i]   = run[i] && !bus.cancel[i] &&
                    ((cnt[i] == '0) || (us_tick && cnt[i] == DW'(1)));
      run_next[i] = grant[i] || (run[i] && !bus.cancel[i] && !expire[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      bus.ack      <= '0;
      bus.busy     <= '0;
      bus.done     <= '0;
      bus.any_busy <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      bus.ack      <= grant;
      bus.busy     <= run_next;
      bus.done     <= expire;
      bus.any_busy <= |run_next;
      if (found) begin
        ptr <= (gidx == PW'(NCH - 1)) ? '0 : gidx + PW'(1);
      end
      for (int i = 0; i < NCH; i++) begin
        case (state[i])
          IDLE: begin
            if (grant[i]) begin
              state[i] <= RUN;
              cnt[i]   <= bus.delay[i*DW +: DW];
            end
          end
          RUN: begin
            if (bus.cancel[i] || expire[i]) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else if (us_tick) begin
              cnt[i] <= cnt[i] - DW'(1);
            end
          end
          default: begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_us_delay_sched.sv
// Directed bench for us_delay_sched: one task per scenario, inline checks,
// one summary line at the end.
module tb_us_delay_sched;
  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int PW  = 2;

  logic clk;
  logic rst_n;
  logic us_tick;
  logic [NCH-1:0] dbg_run;
  logic [PW-1:0]  dbg_ptr;

  int errors;
  int checks;

  us_delay_sched_if #(.NCH(NCH), .DW(DW)) bus ();

  us_delay_sched #(.NCH(NCH), .DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .us_tick (us_tick),
    .bus     (bus),
    .dbg_run (dbg_run),
    .dbg_ptr (dbg_ptr)
  );

  // 50 MHz clock
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // One clock edge with us_tick = t; outputs are stable afterwards.
  task automatic step(input logic t);
    us_tick = t;
    @(posedge clk);
    #1;
    us_tick = 1'b0;
  endtask

  task automatic set_delay(input int ch, input logic [DW-1:0] v);
    bus.delay[ch*DW +: DW] = v;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    us_tick    = 1'b0;
    bus.req    = '0;
    bus.cancel = '0;
    bus.delay  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.ack, bus.busy, bus.done, bus.any_busy} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b busy=%b done=%b any=%b want all 0",
               bus.ack, bus.busy, bus.done, bus.any_busy);
    end
    checks++;
    if (dbg_ptr !== 2'd0) begin
      errors++;
      $display("FAIL reset_ptr: got %0d want 0", dbg_ptr);
    end
  endtask

  task automatic test_single();
    int done_at;
    int busy_bad;
    int ack_bad;
    do_reset();
    step(1'b1);
    for (int n = 0; n < 9; n++) step(1'b0);
    bus.req[0] = 1'b1;
    set_delay(0, 16'd3);
    step(1'b0);
    checks++;
    if (bus.ack !== 4'b0001 || bus.busy !== 4'b0001 || bus.any_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: got ack=%b busy=%b any=%b want 0001 0001 1",
               bus.ack, bus.busy, bus.any_busy);
    end
    bus.req[0] = 1'b0;
    done_at  = -1;
    busy_bad = 0;
    ack_bad  = 0;
    for (int n = 1; n <= 150; n++) begin
      step(((n + 10) % 50) == 0);
      if (bus.ack !== 4'b0000) ack_bad++;
      if (bus.done[0] === 1'b1 && done_at < 0) done_at = n;
      if (n < 140 && bus.busy[0] !== 1'b1) busy_bad++;
      if (n >= 140 && bus.busy[0] !== 1'b0) busy_bad++;
    end
    checks++;
    if (done_at != 140) begin
      errors++;
      $display("FAIL single_done_time: got %0d clk after ack want 140", done_at);
    end
    checks++;
    if (busy_bad != 0 || ack_bad != 0) begin
      errors++;
      $display("FAIL single_busy_span: got %0d busy errors, %0d extra acks want 0 0",
               busy_bad, ack_bad);
    end
  endtask

  task automatic test_contention();
    logic [NCH-1:0] exp_ack;
    do_reset();
    for (int i = 0; i < NCH; i++) set_delay(i, 16'd1);
    bus.req = 4'b1111;
    for (int k = 0; k < NCH; k++) begin
      step(1'b0);
      exp_ack = 4'b0001 << k;
      checks++;
      if (bus.ack !== exp_ack) begin
        errors++;
        $display("FAIL contention_ack%0d: got %b want %b", k, bus.ack, exp_ack);
      end
      bus.req = bus.req & ~exp_ack;
    end
    checks++;
    if (bus.busy !== 4'b1111 || dbg_ptr !== 2'd0) begin
      errors++;
      $display("FAIL contention_busy: got busy=%b ptr=%0d want 1111 0", bus.busy, dbg_ptr);
    end
    step(1'b1);
    checks++;
    if (bus.done !== 4'b1111 || bus.busy !== 4'b0000 || bus.any_busy !== 1'b0) begin
      errors++;
      $display("FAIL contention_expire: got done=%b busy=%b any=%b want 1111 0000 0",
               bus.done, bus.busy, bus.any_busy);
    end
    bus.req = 4'b1010;
    step(1'b0);
    checks++;
    if (bus.ack !== 4'b0010) begin
      errors++;
      $display("FAIL pair_first: got %b want 0010", bus.ack);
    end
    bus.req = 4'b1000;
    step(1'b0);
    checks++;
    if (bus.ack !== 4'b1000) begin
      errors++;
      $display("FAIL pair_second: got %b want 1000", bus.ack);
    end
    bus.req = '0;
  endtask

  task automatic test_zero_and_tick();
    do_reset();
    bus.req[2] = 1'b1;
    set_delay(2, 16'd0);
    step(1'b0);
    bus.req[2] = 1'b0;
    checks++;
    if (bus.ack !== 4'b0100 || bus.busy !== 4'b0100) begin
      errors++;
      $display("FAIL zero_grant: got ack=%b busy=%b want 0100 0100", bus.ack, bus.busy);
    end
    step(1'b0);
    checks++;
    if (bus.done !== 4'b0100 || bus.busy !== 4'b0000) begin
      errors++;
      $display("FAIL zero_done: got done=%b busy=%b want 0100 0000", bus.done, bus.busy);
    end
    bus.req[1] = 1'b1;
    set_delay(1, 16'd2);
    step(1'b1);
    bus.req[1] = 1'b0;
    checks++;
    if (bus.ack !== 4'b0010) begin
      errors++;
      $display("FAIL tick_grant: got ack=%b want 0010", bus.ack);
    end
    for (int n = 0; n < 3; n++) step(1'b0);
    step(1'b1);
    checks++;
    if (bus.done !== 4'b0000 || bus.busy !== 4'b0010) begin
      errors++;
      $display("FAIL tick_first: got done=%b busy=%b want 0000 0010", bus.done, bus.busy);
    end
    step(1'b0);
    step(1'b1);
    checks++;
    if (bus.done !== 4'b0010 || bus.busy !== 4'b0000) begin
      errors++;
      $display("FAIL tick_second: got done=%b busy=%b want 0010 0000", bus.done, bus.busy);
    end
  endtask

  task automatic test_cancel();
    logic [NCH-1:0] seen_done;
    do_reset();
    bus.req[2] = 1'b1;
    set_delay(2, 16'd5);
    step(1'b0);
    bus.req[2] = 1'b0;
    step(1'b1);
    step(1'b1);
    bus.cancel[2] = 1'b1;
    step(1'b0);
    bus.cancel[2] = 1'b0;
    checks++;
    if (bus.busy[2] !== 1'b0 || bus.done[2] !== 1'b0) begin
      errors++;
      $display("FAIL cancel_mid: got busy2=%b done2=%b want 0 0", bus.busy[2], bus.done[2]);
    end
    seen_done = '0;
    for (int n = 0; n < 5; n++) begin
      step(1'b1);
      seen_done = seen_done | bus.done;
    end
    checks++;
    if (seen_done !== 4'b0000) begin
      errors++;
      $display("FAIL cancel_no_done: got done seen=%b want 0000", seen_done);
    end
    bus.req[0] = 1'b1;
    set_delay(0, 16'd1);
    step(1'b0);
    bus.req[0] = 1'b0;
    bus.cancel[0] = 1'b1;
    step(1'b1);
    bus.cancel[0] = 1'b0;
    checks++;
    if (bus.done !== 4'b0000 || bus.busy !== 4'b0000) begin
      errors++;
      $display("FAIL cancel_on_tick: got done=%b busy=%b want 0000 0000", bus.done, bus.busy);
    end
    bus.req[3] = 1'b1;
    bus.cancel[3] = 1'b1;
    step(1'b0);
    checks++;
    if (bus.ack !== 4'b0000) begin
      errors++;
      $display("FAIL cancel_idle_suppress: got ack=%b want 0000", bus.ack);
    end
    bus.cancel[3] = 1'b0;
    step(1'b0);
    bus.req[3] = 1'b0;
    checks++;
    if (bus.ack !== 4'b1000) begin
      errors++;
      $display("FAIL cancel_idle_release: got ack=%b want 1000", bus.ack);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.req[1] = 1'b1;
    set_delay(1, 16'd1);
    step(1'b0);
    step(1'b1);
    checks++;
    if (bus.done !== 4'b0010 || bus.ack !== 4'b0000 || bus.busy !== 4'b0000) begin
      errors++;
      $display("FAIL rearm_done: got done=%b ack=%b busy=%b want 0010 0000 0000",
               bus.done, bus.ack, bus.busy);
    end
    step(1'b0);
    bus.req[1] = 1'b0;
    checks++;
    if (bus.ack !== 4'b0010 || bus.busy !== 4'b0010) begin
      errors++;
      $display("FAIL rearm_ack: got ack=%b busy=%b want 0010 0010", bus.ack, bus.busy);
    end
    do_reset();
    bus.req[0] = 1'b1;
    set_delay(0, 16'd4);
    step(1'b0);
    bus.req[0] = 1'b0;
    step(1'b1);
    bus.req[3] = 1'b1;
    set_delay(3, 16'd3);
    step(1'b0);
    bus.req[3] = 1'b0;
    checks++;
    if (bus.ack !== 4'b1000 || bus.busy !== 4'b1001) begin
      errors++;
      $display("FAIL simul_grant: got ack=%b busy=%b want 1000 1001", bus.ack, bus.busy);
    end
    step(1'b1);
    step(1'b1);
    checks++;
    if (bus.done !== 4'b0000) begin
      errors++;
      $display("FAIL simul_early: got done=%b want 0000", bus.done);
    end
    step(1'b1);
    checks++;
    if (bus.done !== 4'b1001 || bus.any_busy !== 1'b0) begin
      errors++;
      $display("FAIL simul_expire: got done=%b any=%b want 1001 0", bus.done, bus.any_busy);
    end
  endtask

  task automatic test_async_reset();
    logic [NCH-1:0] seen_done;
    do_reset();
    for (int i = 0; i < 3; i++) set_delay(i, 16'd10);
    bus.req = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      step(1'b0);
      bus.req = bus.req & ~bus.ack;
    end
    step(1'b1);
    checks++;
    if (bus.busy !== 4'b0111 || dbg_ptr !== 2'd3) begin
      errors++;
      $display("FAIL areset_setup: got busy=%b ptr=%0d want 0111 3", bus.busy, dbg_ptr);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ack, bus.busy, bus.done, bus.any_busy} !== 13'd0 || dbg_run !== 4'b0000) begin
      errors++;
      $display("FAIL areset_immediate: got ack=%b busy=%b done=%b any=%b run=%b want all 0",
               bus.ack, bus.busy, bus.done, bus.any_busy, dbg_run);
    end
    step(1'b0);
    rst_n = 1'b1;
    seen_done = '0;
    for (int n = 0; n < 12; n++) begin
      step(1'b1);
      seen_done = seen_done | bus.done | bus.busy;
    end
    checks++;
    if (seen_done !== 4'b0000 || dbg_ptr !== 2'd0) begin
      errors++;
      $display("FAIL areset_stale: got done/busy seen=%b ptr=%0d want 0000 0", seen_done, dbg_ptr);
    end
    bus.req = 4'b1001;
    set_delay(0, 16'd1);
    set_delay(3, 16'd1);
    step(1'b0);
    checks++;
    if (bus.ack !== 4'b0001) begin
      errors++;
      $display("FAIL areset_ptr_grant: got ack=%b want 0001", bus.ack);
    end
    bus.req = '0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n      = 1'b0;
    us_tick    = 1'b0;
    bus.req    = '0;
    bus.cancel = '0;
    bus.delay  = '0;
    test_reset();
    test_single();
    test_contention();
    test_zero_and_tick();
    test_cancel();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
